ibr128_host_seq: RTL and testbench

Bus-initiator sequencer that drives the IBR128 CSR slave port (CS/Write/Read/Addr/WData/RData) on behalf of an on-chip client. It accepts one 128-bit cipher job over a valid/ready handshake and programs the key, IV, text and control registers. It then polls the status register until the cipher is ready or a timeout expires, reads back the 128-bit ciphertext, and returns it over a second valid/ready handshake. It sits between a client (DMA or test harness) and the IBR128 block, as the master end of the CSR protocol.

---
 rtl/ibr128_pkg.sv | 48 ++++
 rtl/ibr128_host_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_ibr128_host_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibr128_pkg.sv
// Shared IBR128 CSR map, CTRL bit layout and host sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ibr128_pkg;

  // CSR word addresses (lower address always carries the lower 32 bits)
  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h01;
  localparam logic [4:0] ADDR_KEY0   = 5'h02;
  localparam logic [4:0] ADDR_KEY1   = 5'h04;
  localparam logic [4:0] ADDR_PT     = 5'h06;
  localparam logic [4:0] ADDR_IV     = 5'h0A;
  localparam logic [4:0] ADDR_CT     = 5'h0E;

  // CTRL register bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_SA     = 1;
  localparam int CTRL_ENC    = 2;
  localparam int CTRL_SOM_LO = 3;
  localparam int CTRL_FB     = 5;

  // Key0, key1, plaintext and IV form one contiguous 12-word block from 0x02
  localparam int         N_DATA_WORDS  = 12;
  localparam logic [3:0] LAST_DATA_IDX = 4'd11;
  localparam logic [1:0] LAST_CT_IDX   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_EN,
    S_POLL_RQ,
    S_POLL_CK,
    S_RD_RQ,
    S_RD_CK,
    S_WR_CLR,
    S_DONE
  } state_e;

  // CTRL word: job cfg {FB, SOM[1:0], Encrypt, SA} sits directly above Enable
  function automatic logic [31:0] ctrl_word(input logic [4:0] cfg, input logic en);
    logic [31:0] w;
    w = '0;
    w[CTRL_FB:CTRL_SA] = cfg;
    w[CTRL_EN]         = en;
    return w;
  endfunction

endpackage

// File: rtl/ibr128_host_seq.sv
// CSR-master sequencer: programs one IBR128 job, polls STATUS, reads back ciphertext.
// Latency: accept->res_valid 25 cycles best case, +2 per extra poll; timeout at 15+2*POLL_MAX.
// Backpressure: job_ready only in IDLE; result held in DONE until res_ready, bus idle meanwhile.
module ibr128_host_seq
  import ibr128_pkg::*;
#(
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [4:0]   job_cfg,
  input  logic [127:0] job_key,
  input  logic [127:0] job_iv,
  input  logic [127:0] job_text,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_timeout,
  output logic         CS,
  output logic         Write,
  output logic         Read,
  output logic [4:0]   Addr,
  output logic [31:0]  WData,
  input  logic [31:0]  RData
);

  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(POLL_MAX);

  // sequencing state
  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [1:0]          word_q, word_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;

  // captured job
  logic [4:0]          cfg_q, cfg_d;
  logic [383:0]        data_q, data_d;

  // result side
  logic [127:0]        res_data_q, res_data_d;
  logic                res_timeout_q, res_timeout_d;
  logic                res_valid_q, res_valid_d;
  logic                job_ready_q, job_ready_d;

  // registered CSR bus
  logic                cs_q, cs_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [4:0]          addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  // Next-state, counters, job capture and read-back capture
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    word_d        = word_q;
    poll_cnt_d    = poll_cnt_q;
    cfg_d         = cfg_q;
    data_d        = data_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready_q) begin
          cfg_d         = job_cfg;
          // word i of this bus is written to address 0x02+i
          data_d        = {job_iv, job_text, job_key};
          idx_d         = '0;
          word_d        = '0;
          poll_cnt_d    = '0;
          res_data_d    = '0;
          res_timeout_d = 1'b0;
          state_d       = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        if (idx_q == LAST_DATA_IDX) begin
          state_d = S_WR_EN;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      S_WR_EN: begin
        poll_cnt_d = poll_cnt_q + POLL_W'(1);
        state_d    = S_POLL_RQ;
      end

      S_POLL_RQ: begin
        state_d = S_POLL_CK;
      end

      S_POLL_CK: begin
        // RData carries the STATUS word issued in the previous cycle
        if (RData[0]) begin
          word_d  = '0;
          state_d = S_RD_RQ;
        end else if (poll_cnt_q < POLL_LIMIT) begin
          poll_cnt_d = poll_cnt_q + POLL_W'(1);
          state_d    = S_POLL_RQ;
        end else begin
          res_timeout_d = 1'b1;
          state_d       = S_WR_CLR;
        end
      end

      S_RD_RQ: begin
        state_d = S_RD_CK;
      end

      S_RD_CK: begin
        res_data_d[{word_q, 5'b0} +: 32] = RData;
        if (word_q == LAST_CT_IDX) begin
          state_d = S_WR_CLR;
        end else begin
          word_d  = word_q + 2'd1;
          state_d = S_RD_RQ;
        end
      end

      S_WR_CLR: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus and handshake outputs decoded from the next state so they leave a flop
  always_comb begin
    cs_d        = 1'b0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    res_valid_d = (state_d == S_DONE);
    job_ready_d = (state_d == S_IDLE);

    unique case (state_d)
      S_WR_DATA: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = ADDR_KEY0 + {1'b0, idx_d};
        wdata_d = data_d[{idx_d, 5'b0} +: 32];
      end
      S_WR_EN: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = ctrl_word(cfg_d, 1'b1);
      end
      S_POLL_RQ: begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        addr_d = ADDR_STATUS;
      end
      S_RD_RQ: begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        addr_d = ADDR_CT + {3'b0, word_d};
      end
      S_WR_CLR: begin
        // clear Enable but keep the mode bits, on both success and timeout
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = ctrl_word(cfg_d, 1'b0);
      end
      default: begin
      end
    endcase
  end

  // State and output registers; reset drops every strobe immediately
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      word_q        <= '0;
      poll_cnt_q    <= '0;
      cfg_q         <= '0;
      data_q        <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
      job_ready_q   <= 1'b0;
      cs_q          <= 1'b0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_q        <= word_d;
      poll_cnt_q    <= poll_cnt_d;
      cfg_q         <= cfg_d;
      data_q        <= data_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      res_valid_q   <= res_valid_d;
      job_ready_q   <= job_ready_d;
      cs_q          <= cs_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
    end
  end

  assign job_ready   = job_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign CS          = cs_q;
  assign Write       = wr_q;
  assign Read        = rd_q;
  assign Addr        = addr_q;
  assign WData       = wdata_q;

endmodule

// File: tb/tb_ibr128_host_seq.sv
// Bench for ibr128_host_seq with a behavioural IBR128 CSR responder.
// Latency: n/a.
// Backpressure: exercised via res_ready hold-off and back-to-back jobs.
module tb_ibr128_host_seq;
  import ibr128_pkg::*;

  localparam int P = 4;

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         job_valid = 1'b0;
  logic         job_ready;
  logic [4:0]   job_cfg = '0;
  logic [127:0] job_key = '0, job_iv = '0, job_text = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_data;
  logic         res_timeout;
  logic         CS, Write, Read;
  logic [4:0]   Addr;
  logic [31:0]  WData;
  logic [31:0]  RData = '0;

  ibr128_host_seq #(.POLL_MAX(P)) dut (
    .Clk(Clk), .RstN(RstN),
    .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg),
    .job_key(job_key), .job_iv(job_iv), .job_text(job_text),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout),
    .CS(CS), .Write(Write), .Read(Read), .Addr(Addr), .WData(WData), .RData(RData)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The "cipher" the responder computes from whatever was written to it
  function automatic logic [127:0] cipher_f(input logic [127:0] k, input logic [127:0] iv,
                                            input logic [127:0] t);
    return (k ^ {iv[63:0], iv[127:64]}) + t;
  endfunction

  // ---------------- responder model and bus monitor ----------------
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t          wlog[$];
  logic [31:0]  regs [0:17];
  int           cyc = 0;
  int           viol = 0;
  int           stat_reads = 0;
  int           stat_base = 0;
  int           ready_after = 0;
  logic [127:0] slave_ct;
  logic [4:0]   ct_off;

  assign slave_ct = cipher_f({regs[5], regs[4], regs[3], regs[2]},
                             {regs[13], regs[12], regs[11], regs[10]},
                             {regs[9], regs[8], regs[7], regs[6]});
  assign ct_off = Addr - ADDR_CT;

  initial for (int i = 0; i < 18; i++) regs[i] = '0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (RstN && ((Write && Read) || ((Write || Read) != CS))) viol <= viol + 1;
    if (CS && Write) begin
      wlog.push_back({Addr, WData});
      if (Addr <= 5'h0D) regs[Addr] <= WData;
    end
    if (CS && Read) begin
      if (Addr == ADDR_STATUS) begin
        stat_reads <= stat_reads + 1;
        RData <= {31'd0, (ready_after > 0) && (stat_reads + 1 - stat_base >= ready_after)};
      end else if (Addr >= ADDR_CT && Addr <= ADDR_CT + 5'd3) begin
        RData <= slave_ct[{ct_off[1:0], 5'b0} +: 32];
      end else begin
        RData <= 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- one complete job with checks ----------------
  int wbase = 0;

  task automatic run_job(input string tag, input logic [4:0] cfg, input logic [127:0] key,
                         input logic [127:0] iv, input logic [127:0] text,
                         input int rdy, input int hold, input int exp_lat, input bit exp_to);
    logic [127:0] exp_d;
    int           exp_polls, n, t0;
    logic [383:0] blk;
    wr_t          ew;
    bit           ok;
    ok        = (rdy >= 1) && (rdy <= P);
    exp_polls = ok ? rdy : P;
    exp_d     = ok ? cipher_f(key, iv, text) : 128'd0;
    blk       = {iv, text, key};
    @(negedge Clk);
    ready_after = rdy;
    stat_base   = stat_reads;
    wbase       = wlog.size();
    job_cfg = cfg; job_key = key; job_iv = iv; job_text = text; job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 100) begin @(negedge Clk); n++; end
    chk({tag, "_accept_wait"}, n < 100, 1);
    t0 = cyc;
    @(negedge Clk);
    job_valid = 1'b0;
    job_cfg = ~cfg; job_key = ~key; job_iv = ~iv; job_text = ~text;
    n = 0;
    while (!res_valid && n < 2000) begin @(negedge Clk); n++; end
    chk({tag, "_res_wait"}, n < 2000, 1);
    chk({tag, "_latency"}, cyc - t0, exp_lat);
    chk({tag, "_timeout"}, res_timeout, exp_to);
    chk({tag, "_res_data"}, res_data, exp_d);
    chk({tag, "_polls"}, stat_reads - stat_base, exp_polls);
    chk({tag, "_wr_count"}, wlog.size() - wbase, 14);
    for (int i = 0; i < 14; i++) begin
      if (i < 12) ew = {ADDR_KEY0 + 5'(i), blk[32*i +: 32]};
      else        ew = {ADDR_CTRL, 26'd0, cfg, (i == 12) ? 1'b1 : 1'b0};
      chk($sformatf("%s_wr%0d", tag, i), (wbase + i < wlog.size()) ? wlog[wbase + i] : 'x, ew);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_data"}, {res_timeout, res_data}, {exp_to, exp_d});
      chk({tag, "_hold_jrdy"}, job_ready, 0);
      chk({tag, "_hold_bus"}, {CS, Write, Read}, 0);
    end
    res_ready = 1'b1;
    @(negedge Clk);
    res_ready = 1'b0;
    chk({tag, "_res_drop"}, res_valid, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [4:0]   cfg;
    logic [127:0] key, iv, text;
    int           rdy, hold, lat;
    bit           to;
  } vec_t;

  vec_t vt[5];
  int   acc_c[$];
  int   hs_c[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

  initial begin
    int n, wcnt, rdy, lat;
    bit to;
    vt[0] = '{5'b00100, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
              128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF,
              128'h5F5E5D5C_5B5A5958_57565554_53525150, 3, 0, 29, 1'b0};
    vt[1] = '{5'b10110, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
              128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
              128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_FACE_B00C, 0, 0, 23, 1'b1};
    vt[2] = '{5'b01011, 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0,
              128'h0000_0001_0000_0002_0000_0003_0000_0004,
              128'h8000_0000_0000_0000_0000_0000_0000_0001, 1, 10, 25, 1'b0};
    vt[3] = '{5'b11111, 128'h2, 128'h3, 128'h4, 4, 2, 31, 1'b0};
    vt[4] = '{5'b00001, 128'h5, 128'h6, 128'h7, 5, 3, 23, 1'b1};

    // reset state
    #3;
    chk("rst_job_ready", job_ready, 0);
    chk("rst_res", {res_valid, res_timeout, res_data}, 0);
    chk("rst_bus", {CS, Write, Read, Addr, WData}, 0);
    repeat (2) @(negedge Clk);
    RstN = 1'b1;
    @(negedge Clk);
    chk("idle_job_ready", job_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_job($sformatf("vec%0d", i), vt[i].cfg, vt[i].key, vt[i].iv, vt[i].text,
              vt[i].rdy, vt[i].hold, vt[i].lat, vt[i].to);
      if (i == 0) begin
        chk("wo_addr2", (wlog.size() > wbase + 3) ? wlog[wbase] : 'x, {5'h02, 32'h03020100});
        chk("wo_addr5", (wlog.size() > wbase + 3) ? wlog[wbase + 3] : 'x, {5'h05, 32'h0F0E0D0C});
      end
    end

    // randomized jobs against the job-level model
    for (int i = 0; i < 6; i++) begin
      rdy = $urandom_range(0, P + 1);
      to  = !(rdy >= 1 && rdy <= P);
      lat = to ? 15 + 2 * P : 23 + 2 * rdy;
      run_job($sformatf("rnd%0d", i), 5'($urandom),
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              rdy, $urandom_range(0, 3), lat, to);
    end

    // reset during the second STATUS poll
    @(negedge Clk);
    ready_after = 0;
    stat_base = stat_reads;
    job_cfg = 5'b00110; job_key = 128'h9; job_iv = 128'hA; job_text = 128'hB;
    job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 100) begin @(negedge Clk); n++; end
    @(negedge Clk);
    job_valid = 1'b0;
    n = 0;
    while (!(Read && Addr == ADDR_STATUS && stat_reads - stat_base == 1) && n < 200) begin
      @(negedge Clk); n++;
    end
    chk("mid_rst_reach_poll2", n < 200, 1);
    #1 RstN = 1'b0;
    #1;
    chk("mid_rst_strobes", {CS, Write, Read}, 0);
    chk("mid_rst_job_ready", job_ready, 0);
    wcnt = wlog.size();
    repeat (3) @(negedge Clk);
    RstN = 1'b1;
    repeat (3) @(negedge Clk);
    chk("mid_rst_idle", job_ready, 1);
    chk("mid_rst_no_clear", wlog.size(), wcnt);
    chk("mid_rst_res", {res_valid, res_timeout}, 0);
    run_job("recover", 5'b00100, 128'h77, 128'h88, 128'h99, 2, 0, 27, 1'b0);

    // back-to-back jobs with job_valid and res_ready held high
    @(negedge Clk);
    ready_after = 1;
    stat_base = stat_reads;
    job_cfg = 5'b01100; job_key = 128'h1234; job_iv = 128'h5678; job_text = 128'h9ABC;
    job_valid = 1'b1;
    res_ready = 1'b1;
    n = 0;
    while (acc_c.size() < 2 && n < 300) begin
      if (job_ready) acc_c.push_back(cyc);
      if (res_valid) hs_c.push_back(cyc);
      @(negedge Clk); n++;
    end
    job_valid = 1'b0;
    chk("b2b_accepts", acc_c.size(), 2);
    chk("b2b_first_lat", (hs_c.size() > 0 && acc_c.size() > 0) ? hs_c[0] - acc_c[0] : -1, 25);
    chk("b2b_gap", (hs_c.size() > 0 && acc_c.size() > 1) ? acc_c[1] - hs_c[0] : -1, 1);
    n = 0;
    while (!res_valid && n < 200) begin @(negedge Clk); n++; end
    chk("b2b_second_res", res_valid, 1);
    @(negedge Clk);
    res_ready = 1'b0;
    chk("b2b_second_drop", res_valid, 0);

    chk("bus_protocol_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
